// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared funct3 codes, FSM encoding and access-legality check
package mem_access_unit_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  // Unsigned widths exist only for loads, so a BU/HU store is as illegal as a bad code
  function automatic logic is_fault(input logic [2:0] f3, input logic [1:0] a, input logic wr);
    return f3 == F3_B  ? 1'b0 :
           f3 == F3_BU ? wr :
           f3 == F3_H  ? a[0] :
           f3 == F3_HU ? (wr | a[0]) :
           f3 == F3_W  ? |a : 1'b1;
  endfunction
endpackage

// File: rtl/mem_load_extend.sv
// mem_load_extend: selects the addressed byte/half of a read word and sign/zero extends it
module mem_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  f3_i,
  output logic [31:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = 8'(rdata_i >> {off_i, 3'b000});
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = f3_i == F3_B  ? {{24{b[7]}}, b} :
             f3_i == F3_BU ? {24'd0, b} :
             f3_i == F3_H  ? {{16{h[15]}}, h} :
             f3_i == F3_HU ? {16'd0, h} : rdata_i;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage bus initiator with ack wait, timeout abort and load alignment
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [31:0] MEM_IR,
  input  logic [31:0] MEM_ALUO,
  input  logic [31:0] MEM_Data_out,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic [31:0] Datai,
  output logic        stall,
  output logic        access_fault,
  output logic        bus_err
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d, we_q, we_d, fault_q, fault_d, err_q, err_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]    be_q, be_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;
  logic [2:0]    f3;
  logic [1:0]    a;
  logic          access, fault, timeout, unused_ir;
  assign f3        = MEM_IR[14:12];
  assign a         = MEM_ALUO[1:0];
  assign unused_ir = ^{MEM_IR[31:15], MEM_IR[11:0]};
  assign access    = MEM_MemRead | MEM_MemWrite;
  assign fault     = is_fault(f3, a, MEM_MemWrite);
  assign timeout   = cnt_q == CW'(TIMEOUT - 1);
  assign stall     = (state_q == IDLE && access && !fault) || state_q == WAIT;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    off_d   = off_q;
    f3_d    = f3_q;
    fault_d = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE && access && fault) begin
      // A zero word viewed as W makes Datai read 0 after a rejected access
      fault_d = 1'b1;
      rdata_d = '0;
      off_d   = '0;
      f3_d    = F3_W;
    end else if (state_q == IDLE && access) begin
      state_d = WAIT;
      req_d   = 1'b1;
      cnt_d   = '0;
      we_d    = MEM_MemWrite;
      addr_d  = {MEM_ALUO[31:2], 2'b00};
      wdata_d = f3 == F3_B ? {4{MEM_Data_out[7:0]}} :
                f3 == F3_H ? {2{MEM_Data_out[15:0]}} : MEM_Data_out;
      be_d    = !MEM_MemWrite ? 4'hF :
                f3 == F3_B    ? 4'b0001 << a :
                f3 == F3_H    ? 4'b0011 << {a[1], 1'b0} : 4'hF;
      off_d   = a;
      f3_d    = f3;
    end else if (state_q == WAIT && (bus_ack || timeout)) begin
      state_d = DONE;
      req_d   = 1'b0;
      rdata_d = bus_ack ? bus_rdata : '0;
      err_d   = !bus_ack;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      fault_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      fault_q <= fault_d;
      err_q   <= err_d;
    end
  end
  assign bus_req      = req_q;
  assign bus_we       = we_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign bus_be       = be_q;
  assign access_fault = fault_q;
  assign bus_err      = err_q;
  mem_load_extend u_ext (
    .rdata_i (rdata_q),
    .off_i   (off_q),
    .f3_i    (f3_q),
    .data_o  (Datai)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench driving loads/stores, faults, timeouts and reset
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_MemRead = 1'b0, MEM_MemWrite = 1'b0, bus_ack = 1'b0;
  logic [31:0] MEM_IR = '0, MEM_ALUO = '0, MEM_Data_out = '0, bus_rdata = '0;
  logic        bus_req, bus_we, stall, access_fault, bus_err;
  logic [31:0] bus_addr, bus_wdata, Datai;
  logic [3:0]  bus_be;
  int n_chk = 0, n_err = 0;
  logic [31:0] sb[$];
  mem_access_unit dut (
    .clk(clk), .rst(rst), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_IR(MEM_IR), .MEM_ALUO(MEM_ALUO), .MEM_Data_out(MEM_Data_out),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .Datai(Datai),
    .stall(stall), .access_fault(access_fault), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] ext(input logic [31:0] r, input logic [1:0] o, input logic [2:0] f);
    logic [31:0] s = r >> (8 * o);
    logic [31:0] h = r >> (16 * o[1]);
    case (f)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b001:  return {{16{h[15]}}, h[15:0]};
      3'b101:  return {16'd0, h[15:0]};
      default: return r;
    endcase
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data);
    MEM_MemRead  = rd;
    MEM_MemWrite = wr;
    MEM_IR       = {17'd0, f3, 12'h003};
    MEM_ALUO     = addr;
    MEM_Data_out = data;
  endtask
  // dly = WAIT cycles before the ack is offered; negative means never ack
  task automatic xfer(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] rdata, input int dly,
                      input logic [31:0] exp_wd, input logic [3:0] exp_be);
    int n = 0;
    int st = 0;
    set_in(rd, wr, f3, addr, data);
    if (rd) sb.push_back(dly < 0 ? 32'd0 : ext(rdata, addr[1:0], f3));
    #1;
    chk("stall_idle", {31'd0, stall}, 32'd1);
    step();
    chk("req_rise", {31'd0, bus_req}, 32'd1);
    chk("addr", bus_addr, {addr[31:2], 2'b00});
    chk("we", {31'd0, bus_we}, {31'd0, wr});
    chk("be", {28'd0, bus_be}, {28'd0, exp_be});
    if (wr) chk("wdata", bus_wdata, exp_wd);
    while (bus_req && n < 40) begin
      st += int'(stall);
      bus_ack   = (n == dly);
      bus_rdata = rdata;
      step();
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
      n++;
    end
    chk("wait_cycles", 32'(n), dly < 0 ? 32'd16 : 32'(dly + 1));
    chk("stall_wait", 32'(st), 32'(n));
    chk("stall_done", {31'd0, stall}, 32'd0);
    chk("bus_err", {31'd0, bus_err}, {31'd0, dly < 0});
    if (rd && sb.size() > 0) chk("datai", Datai, sb.pop_front());
    set_in(0, 0, 3'b000, 32'd0, 32'd0);
    step();
    chk("err_clear", {31'd0, bus_err}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    step();
    step();
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_datai", Datai, 32'd0);
    chk("rst_flags", {29'd0, stall, access_fault, bus_err}, 32'd0);
    rst = 1'b0;
    step();
    xfer(1, 0, 3'b010, 32'h100, 32'd0, 32'h12345678, 1, 32'd0, 4'hF);
    xfer(1, 0, 3'b000, 32'h103, 32'd0, 32'h80FF1234, 0, 32'd0, 4'hF);
    xfer(1, 0, 3'b100, 32'h103, 32'd0, 32'h80FF1234, 2, 32'd0, 4'hF);
    xfer(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 32'd0, 0, 32'hABCDABCD, 4'b1100);
    xfer(0, 1, 3'b000, 32'h201, 32'h000000A5, 32'd0, 3, 32'hA5A5A5A5, 4'b0010);
    xfer(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'd0, 1, 32'hCAFEF00D, 4'hF);
    xfer(1, 0, 3'b101, 32'h302, 32'd0, 32'h9ABC0000, 0, 32'd0, 4'hF);
    set_in(1, 0, 3'b010, 32'h1001, 32'd0);
    #1;
    chk("fault_stall", {31'd0, stall}, 32'd0);
    step();
    chk("fault_pulse", {31'd0, access_fault}, 32'd1);
    chk("fault_noreq", {31'd0, bus_req}, 32'd0);
    chk("fault_datai", Datai, 32'd0);
    set_in(0, 0, 3'b000, 32'd0, 32'd0);
    step();
    chk("fault_clear", {31'd0, access_fault}, 32'd0);
    set_in(0, 1, 3'b100, 32'h400, 32'h11);
    step();
    chk("fault_sbu", {31'd0, access_fault}, 32'd1);
    chk("fault_sbu_req", {31'd0, bus_req}, 32'd0);
    set_in(0, 0, 3'b000, 32'd0, 32'd0);
    step();
    xfer(1, 0, 3'b010, 32'h500, 32'd0, 32'h55555555, -1, 32'd0, 4'hF);
    for (int i = 0; i < 16; i++) begin
      logic [2:0] f;
      logic [31:0] ad;
      int k = $urandom_range(0, 4);
      f  = k == 0 ? 3'b000 : k == 1 ? 3'b001 : k == 2 ? 3'b010 : k == 3 ? 3'b100 : 3'b101;
      ad = $urandom & 32'hFFFF_FFFC;
      ad[1:0] = f[1] ? 2'b00 : f[0] ? {1'($urandom), 1'b0} : 2'($urandom);
      xfer(1, 0, f, ad, 32'd0, $urandom, $urandom_range(0, 4), 32'd0, 4'hF);
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    step();
    bus_ack = 1'b0;
    chk("idle_ack_req", {31'd0, bus_req}, 32'd0);
    chk("idle_ack_stall", {31'd0, stall}, 32'd0);
    set_in(1, 0, 3'b010, 32'h600, 32'd0);
    step();
    chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    set_in(0, 0, 3'b000, 32'd0, 32'd0);
    step();
    chk("rst_mid_req", {31'd0, bus_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    rst       = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEADBEEF;
    step();
    bus_ack = 1'b0;
    chk("late_ack_req", {31'd0, bus_req}, 32'd0);
    chk("late_ack_datai", Datai, 32'd0);
    chk("late_ack_err", {31'd0, bus_err}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
